pixel_array_ctrl: RTL and testbench

- Digital sequencer for an N_ROWS x N_COLS array of PIXEL_SENSOR cells.
- Runs one full frame per start request: erase, exposure, ramp/counter conversion, then row-by-row readout.
- Drives the array's ERASE/EXPOSE/RAMP-phase/READ controls and drives the shared count onto the array DATA bus during conversion.
- Streams captured pixel codes out one word per transfer over a valid/ready interface to the downstream frame logic.

---
 rtl/pixel_array_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a pixel sensor array: erase, expose, ramp conversion, row readout, valid/ready stream.
// Optional Gray-coded conversion count is enabled by defining PIXEL_CTRL_GRAY_CNT_EN.
module pixel_array_ctrl #(
  parameter int N_ROWS       = 2,
  parameter int N_COLS       = 2,
  parameter int DATA_W       = 8,
  parameter int ERASE_CYCLES = 5,
  parameter int READ_SETTLE  = 2,
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int KW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [15:0]              exp_cycles,
  output logic                     busy,
  output logic                     erase,
  output logic                     expose,
  output logic                     convert,
  output logic [DATA_W-1:0]        cnt_out,
  output logic                     cnt_oe,
  output logic [N_ROWS-1:0]        read,
  input  logic [N_COLS*DATA_W-1:0] col_data,
  output logic [DATA_W-1:0]        pix_data,
  output logic [RW-1:0]            pix_row,
  output logic [KW-1:0]            pix_col,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     frame_done
);

  // Phase counter must hold both the 16-bit exposure length and the full ramp length.
  localparam int CW = (DATA_W + 1 > 16) ? DATA_W + 1 : 16;
  localparam logic [CW-1:0] ERASE_LAST = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST  = CW'((1 << DATA_W) - 1);
  localparam logic [CW-1:0] READ_LAST  = CW'(READ_SETTLE - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(N_ROWS - 1);
  localparam logic [KW-1:0] COL_LAST   = KW'(N_COLS - 1);

  typedef enum logic [2:0] {
    IDLE, ERASE, EXPOSE, CONVERT, ROWSEL, STREAM, DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [CW-1:0]   exp_last_reg, exp_last_next;
  logic [RW-1:0]   row_reg, row_next;
  logic [KW-1:0]   col_reg, col_next;
  logic            capture;
  logic [DATA_W-1:0] lane_bus [N_COLS];
  logic [DATA_W-1:0] ramp_code;

`ifdef PIXEL_CTRL_GRAY_CNT_EN
  function automatic logic [DATA_W-1:0] lane_decode(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b[DATA_W-1] = g[DATA_W-1];
    for (int i = DATA_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
  assign ramp_code = cnt_reg[DATA_W-1:0] ^ (cnt_reg[DATA_W-1:0] >> 1);
`else
  function automatic logic [DATA_W-1:0] lane_decode(input logic [DATA_W-1:0] g);
    return g;
  endfunction
  assign ramp_code = cnt_reg[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      exp_last_reg <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      exp_last_reg <= exp_last_next;
      row_reg      <= row_next;
      col_reg      <= col_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    exp_last_next = exp_last_reg;
    row_next      = row_reg;
    col_next      = col_reg;
    capture       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = ERASE;
          cnt_next      = '0;
          // Zero exposure behaves as a single-cycle exposure.
          exp_last_next = (exp_cycles == 16'd0) ? '0 : CW'(exp_cycles - 16'd1);
        end
      end
      ERASE: begin
        if (cnt_reg == ERASE_LAST) begin
          state_next = EXPOSE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      EXPOSE: begin
        if (cnt_reg == exp_last_reg) begin
          state_next = CONVERT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      CONVERT: begin
        if (cnt_reg == CONV_LAST) begin
          state_next = ROWSEL;
          cnt_next   = '0;
          row_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ROWSEL: begin
        if (cnt_reg == READ_LAST) begin
          state_next = STREAM;
          cnt_next   = '0;
          col_next   = '0;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STREAM: begin
        if (pix_ready) begin
          if (col_reg == COL_LAST) begin
            cnt_next = '0;
            if (row_reg == ROW_LAST) begin
              state_next = DONE;
            end else begin
              state_next = ROWSEL;
              row_next   = row_reg + 1'b1;
            end
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Row buffer: one register per column lane, loaded on the last settle cycle.
  generate
    for (genvar gi = 0; gi < N_COLS; gi++) begin : g_lane
      logic [DATA_W-1:0] lane_reg;
      always_ff @(posedge clk) begin
        if (capture) begin
          lane_reg <= lane_decode(col_data[gi*DATA_W +: DATA_W]);
        end
      end
      assign lane_bus[gi] = lane_reg;
    end
  endgenerate

  assign busy       = (state_reg != IDLE);
  assign erase      = (state_reg == ERASE);
  assign expose     = (state_reg == EXPOSE);
  assign convert    = (state_reg == CONVERT);
  assign cnt_oe     = convert;
  assign cnt_out    = convert ? ramp_code : '0;
  assign read       = (state_reg == ROWSEL) ? (N_ROWS'(1) << row_reg) : '0;
  assign pix_valid  = (state_reg == STREAM);
  assign pix_data   = pix_valid ? lane_bus[col_reg] : '0;
  assign pix_row    = pix_valid ? row_reg : '0;
  assign pix_col    = pix_valid ? col_reg : '0;
  assign frame_done = (state_reg == DONE);

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed self-checking bench for pixel_array_ctrl; follows PIXEL_CTRL_GRAY_CNT_EN when defined.
module tb_pixel_array_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, pix_ready;
  logic [15:0] exp_cycles;
  logic        busy, erase, expose, convert, cnt_oe, pix_valid, frame_done;
  logic [7:0]  cnt_out, pix_data;
  logic [1:0]  read;
  logic [15:0] col_data = 16'hDEAD;
  logic [0:0]  pix_row, pix_col;

  pixel_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .exp_cycles(exp_cycles),
    .busy(busy), .erase(erase), .expose(expose), .convert(convert),
    .cnt_out(cnt_out), .cnt_oe(cnt_oe), .read(read), .col_data(col_data),
    .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc, read_run;
  int erase_n, expose_n, convert_n, oe_n, read0_n, read1_n, done_n;
  int conv_err, excl_err, hold_err;
  bit stall_prev;
  logic [7:0] stall_data;
  logic [15:0] pat0, pat1;
  int xcyc[$], xrow[$], xcol[$];
  logic [7:0] xdat[$];

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [7:0] exp_code(input int k);
    logic [7:0] kk;
    kk = k[7:0];
`ifdef PIXEL_CTRL_GRAY_CNT_EN
    return kk ^ (kk >> 1);
`else
    return kk;
`endif
  endfunction

  function automatic logic [7:0] exp_word(input logic [7:0] lane);
`ifdef PIXEL_CTRL_GRAY_CNT_EN
    return g2b(lane);
`else
    return lane;
`endif
  endfunction

  // Monitor and array model: runs just after each falling edge, after the tasks drive inputs.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (read != 2'b00) read_run++; else read_run = 0;
    col_data = (read_run == 2) ? (read[0] ? pat0 : pat1) : 16'hDEAD;
    if (erase)  erase_n++;
    if (expose) expose_n++;
    if (convert) begin
      if (cnt_out !== exp_code(convert_n)) conv_err++;
      convert_n++;
    end
    if (cnt_oe) oe_n++;
    if (read == 2'b01) read0_n++;
    if (read == 2'b10) read1_n++;
    if (read == 2'b11) excl_err++;
    if (int'(erase) + int'(expose) + int'(convert) + int'(read != 2'b00) > 1) excl_err++;
    if (cnt_oe && read != 2'b00) excl_err++;
    if (frame_done) done_n++;
    if (stall_prev && (!pix_valid || pix_data !== stall_data)) hold_err++;
    stall_prev = pix_valid && !pix_ready && !reset;
    stall_data = pix_data;
    if (pix_valid && pix_ready && !reset) begin
      xcyc.push_back(cyc);
      xrow.push_back(int'(pix_row));
      xcol.push_back(int'(pix_col));
      xdat.push_back(pix_data);
      $display("[TB] xfer row=%0d col=%0d data=%02h", pix_row, pix_col, pix_data);
    end
  end

  task automatic clear_stats();
    erase_n = 0; expose_n = 0; convert_n = 0; oe_n = 0; read0_n = 0; read1_n = 0;
    done_n = 0; conv_err = 0; excl_err = 0; hold_err = 0;
    xcyc.delete(); xrow.delete(); xcol.delete(); xdat.delete();
  endtask

  task automatic pulse_start(input logic [15:0] e);
    @(negedge clk);
    exp_cycles = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_cycles = 16'hFFFF;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pix_ready = 1'b1; exp_cycles = 16'd0;
    pat0 = 16'h0; pat1 = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({busy, erase, expose, convert, cnt_oe, read, pix_valid, frame_done, pix_row, pix_col} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0",
               {busy, erase, expose, convert, cnt_oe, read, pix_valid, frame_done, pix_row, pix_col});
    end
    n_tests++;
    if (cnt_out !== 8'h00) begin n_fail++; $display("FAIL reset_cnt_out: got %02h required 00", cnt_out); end
    n_tests++;
    if (pix_data !== 8'h00) begin n_fail++; $display("FAIL reset_pix_data: got %02h required 00", pix_data); end
  endtask

  // Checks the four words of a completed frame against the row patterns.
  task automatic check_words(input string tag, input logic [15:0] p0, input logic [15:0] p1);
    logic [7:0] want [4];
    want[0] = exp_word(p0[7:0]);  want[1] = exp_word(p0[15:8]);
    want[2] = exp_word(p1[7:0]);  want[3] = exp_word(p1[15:8]);
    n_tests++;
    if (xdat.size() != 4) begin
      n_fail++;
      $display("FAIL %s_xfer_count: got %0d required 4", tag, xdat.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (xdat[i] !== want[i] || xrow[i] != i / 2 || xcol[i] != i % 2) begin
          n_fail++;
          $display("FAIL %s_word%0d: got r%0d c%0d %02h required r%0d c%0d %02h",
                   tag, i, xrow[i], xcol[i], xdat[i], i / 2, i % 2, want[i]);
        end
      end
    end
  endtask

  task automatic test_frame();
    bit ok;
    pat0 = 16'hA55A; pat1 = 16'h3CC3; pix_ready = 1'b1;
    clear_stats();
    pulse_start(16'd3);
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL frame_timeout: got no frame_done required frame_done"); end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_done: got %b required 1", busy); end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_idle_after: got busy=%b done=%b required 0 0", busy, frame_done);
    end
    @(negedge clk);
    n_tests++;
    if (erase_n != 5) begin n_fail++; $display("FAIL erase_len: got %0d required 5", erase_n); end
    n_tests++;
    if (expose_n != 3) begin n_fail++; $display("FAIL expose_len: got %0d required 3", expose_n); end
    n_tests++;
    if (convert_n != 256 || oe_n != 256) begin
      n_fail++;
      $display("FAIL convert_len: got convert=%0d oe=%0d required 256 256", convert_n, oe_n);
    end
    n_tests++;
    if (conv_err != 0) begin n_fail++; $display("FAIL cnt_out_seq: got %0d bad codes required 0", conv_err); end
    n_tests++;
    if (read0_n != 2 || read1_n != 2) begin
      n_fail++;
      $display("FAIL read_len: got r0=%0d r1=%0d required 2 2", read0_n, read1_n);
    end
    n_tests++;
    if (excl_err != 0) begin n_fail++; $display("FAIL exclusive: got %0d overlaps required 0", excl_err); end
    n_tests++;
    if (done_n != 1) begin n_fail++; $display("FAIL done_pulse: got %0d cycles required 1", done_n); end
    check_words("frame", 16'hA55A, 16'h3CC3);
    if (xcyc.size() == 4) begin
      n_tests++;
      if (xcyc[1] - xcyc[0] != 1 || xcyc[3] - xcyc[2] != 1) begin
        n_fail++;
        $display("FAIL back_to_back: got gaps %0d %0d required 1 1", xcyc[1] - xcyc[0], xcyc[3] - xcyc[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, found;
    pat0 = 16'hA55A; pat1 = 16'h3CC3; pix_ready = 1'b0;
    clear_stats();
    pulse_start(16'd3);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (pix_valid) begin found = 1'b1; break; end
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL bp_valid_timeout: got no pix_valid required pix_valid"); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (pix_valid !== 1'b1 || pix_data !== exp_word(8'h5A) || pix_row !== 1'b0 || pix_col !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b %02h r%0d c%0d required v=1 %02h r0 c0",
                 i, pix_valid, pix_data, pix_row, pix_col, exp_word(8'h5A));
      end
      @(negedge clk);
    end
    pix_ready = 1'b1;
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no frame_done required frame_done"); end
    repeat (2) @(negedge clk);
    n_tests++;
    if (hold_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes required 0", hold_err); end
    check_words("bp", 16'hA55A, 16'h3CC3);
  endtask

  task automatic test_exp_zero_ignored_start();
    bit ok, found;
    pat0 = 16'h1234; pat1 = 16'h5678; pix_ready = 1'b1;
    clear_stats();
    pulse_start(16'd0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (expose) begin found = 1'b1; break; end
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (pix_valid) begin found = 1'b1; break; end
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL ez_valid_timeout: got no pix_valid required pix_valid"); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ez_timeout: got no frame_done required frame_done"); end
    repeat (30) @(negedge clk);
    n_tests++;
    if (expose_n != 1) begin n_fail++; $display("FAIL exp_zero_len: got %0d required 1", expose_n); end
    n_tests++;
    if (done_n != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: got done=%0d busy=%b required 1 0", done_n, busy);
    end
    check_words("ez", 16'h1234, 16'h5678);
  endtask

  task automatic test_reset_mid_convert();
    bit ok, found;
    pat0 = 16'hF00F; pat1 = 16'h8001; pix_ready = 1'b1;
    clear_stats();
    pulse_start(16'd3);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (convert && convert_n == 99) begin found = 1'b1; break; end
    end
    n_tests++;
    if (!found || cnt_out !== exp_code(99)) begin
      n_fail++;
      $display("FAIL conv100_cnt: got found=%b %02h required 1 %02h", found, cnt_out, exp_code(99));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({busy, erase, expose, convert, cnt_oe, read, pix_valid, frame_done, cnt_out, pix_data} !== 25'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b required 0",
               {busy, erase, expose, convert, cnt_oe, read, pix_valid, frame_done, cnt_out, pix_data});
    end
    @(negedge clk);
    clear_stats();
    pulse_start(16'd2);
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL mr_timeout: got no frame_done required frame_done"); end
    repeat (2) @(negedge clk);
    n_tests++;
    if (erase_n != 5 || expose_n != 2 || convert_n != 256 || conv_err != 0) begin
      n_fail++;
      $display("FAIL mr_phases: got e=%0d x=%0d c=%0d err=%0d required 5 2 256 0",
               erase_n, expose_n, convert_n, conv_err);
    end
    check_words("mr", 16'hF00F, 16'h8001);
  endtask

  task automatic test_lane_code();
    bit ok;
    pat0 = 16'h0303; pat1 = 16'h0706; pix_ready = 1'b1;
    clear_stats();
    pulse_start(16'd1);
    wait_done(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL lane_timeout: got no frame_done required frame_done"); end
    repeat (2) @(negedge clk);
    n_tests++;
`ifdef PIXEL_CTRL_GRAY_CNT_EN
    if (xdat.size() < 1 || xdat[0] !== 8'h02) begin
      n_fail++;
      $display("FAIL lane03_decode: got %02h required 02", (xdat.size() > 0) ? xdat[0] : 8'hxx);
    end
`else
    if (xdat.size() < 1 || xdat[0] !== 8'h03) begin
      n_fail++;
      $display("FAIL lane03_raw: got %02h required 03", (xdat.size() > 0) ? xdat[0] : 8'hxx);
    end
`endif
    check_words("lane", 16'h0303, 16'h0706);
  endtask

  initial begin
    cyc = 0; read_run = 0; stall_prev = 1'b0; stall_data = 8'h00;
    clear_stats();
    test_reset();
    test_frame();
    test_backpressure();
    test_exp_zero_ignored_start();
    test_reset_mid_convert();
    test_lane_code();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
